timer_mmio: RTL and testbench
=============================

TIMER_MMIO -- requirements
Module: timer_mmio

Interface
REQ-001 Parameter N, default 32: data/address width.
REQ-002 Parameter BASE, default 'h5200: timer window base address.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 WEtimer  input  1  write enable from the address decoder; high only for timer-region stores.
REQ-006 DataAdr  input  N  byte address of the current load/store.
REQ-007 WriteData  input  N  store data.
REQ-008 ReadData  output  N  load data for the read-data mux (timer leg); combinational from DataAdr and registers.
REQ-009 irq  output  1  level interrupt = STATUS.EXP & CTRL.IE.

Function
REQ-010 Register map, word-aligned:
- BASE+0 CTRL: bit0 EN, bit1 AR (auto-reload), bit2 IE; other bits read 0.
- BASE+4 LOAD: 32-bit.
- BASE+8 COUNT: read-only.
- BASE+C STATUS: bit0 EXP; write-1-to-clear.
- BASE+10 PRESC: bits[7:0].
REQ-011 A write occurs only when WEtimer=1, DataAdr[1:0]=00 and DataAdr equals a mapped offset; all other writes are ignored, with no state change.
REQ-012 Writes to COUNT are ignored; reads of unmapped or misaligned addresses return 0.
REQ-013 State machine, states IDLE, RUN, DONE; reset state IDLE.
REQ-014 IDLE->RUN: a CTRL write with EN=1 while in IDLE or DONE; same edge: COUNT<=LOAD, prescaler counter PC<=0.
REQ-015 RUN->IDLE: a CTRL write with EN=0; COUNT and PC hold their values; EXP is unchanged.
REQ-016 A CTRL write with EN=1 while in RUN updates AR/IE only; it does not restart the count.
REQ-017 Prescaler in RUN:
- PC increments each cycle.
- When PC==PRESC, PC<=0 and a tick occurs.
- PRESC=0 gives a tick every cycle.
REQ-018 On a tick with COUNT!=0, COUNT<=COUNT-1.
REQ-019 On a tick with COUNT==0 (expiry):
- EXP<=1.
- If AR=1: COUNT<=LOAD, stay in RUN.
- If AR=0: go to DONE, CTRL.EN<=0, COUNT holds 0.
REQ-020 Expiry period = (LOAD+1)*(PRESC+1) cycles from the enabling write edge to the EXP set edge; LOAD=0 expires on every tick.
REQ-021 A LOAD write while in RUN takes effect only at the next reload or restart.
REQ-022 A PRESC write while in RUN takes effect immediately; if new PRESC < PC, PC counts on and wraps at 8 bits before the next tick.
REQ-023 Simultaneous expiry and STATUS write-1-clear in the same cycle: the set wins, so EXP=1.
REQ-024 DONE behaves as IDLE for counting (no ticks); CTRL.EN reads 0.
REQ-025 No arithmetic wraps below 0: a decrement never occurs at COUNT==0.

Reset
REQ-026 While reset_n=0, asynchronously:
- CTRL, LOAD, COUNT, STATUS, PRESC and PC are all 0.
- State is IDLE.
- irq=0.
- ReadData reflects the zeroed registers.
REQ-027 Reset asserted mid-count aborts the count immediately; after release the timer stays in IDLE until EN is written.

Verification
REQ-028 LOAD=3, PRESC=0, CTRL=1 -> COUNT reads 3,2,1,0 on successive cycles; EXP=1 on the 4th edge after the enable edge; state DONE; CTRL reads 0.
REQ-029 LOAD=1, PRESC=2, CTRL=3 -> EXP set 6 cycles after enable; COUNT reloads to 1 and counting continues; EXP stays set until STATUS written with 1.
REQ-030 CTRL=7, expiry with IE=1 -> irq=1; write STATUS=1 -> irq=0 the next cycle; write STATUS=1 on the expiry cycle -> EXP remains 1.
REQ-031 WEtimer=0 with DataAdr=BASE+0 and WriteData=1 -> no start. Write to BASE+2 -> ignored. Write COUNT=5 -> COUNT unchanged. Read BASE+14 -> 0.
REQ-032 LOAD=10, running at COUNT=6, reset_n pulsed low -> all reads return 0 and irq=0 immediately; after release COUNT stays 0 with no ticks until CTRL=1.
REQ-033 Running with LOAD=8: write LOAD=2, then write CTRL=0, then write CTRL=1 -> COUNT held on disable, then restarts at 2.

Source files
------------

// File: rtl/timer_mmio.sv
// timer_mmio: memory-mapped down-counting timer with 8-bit prescaler,
// auto-reload and level interrupt.
// Ports:
//   clk        - clock, all state updates on the rising edge
//   reset_n    - asynchronous active-low reset
//   WEtimer    - store enable for the timer window
//   DataAdr    - byte address of the current load/store
//   WriteData  - store data
//   ReadData   - combinational load data (timer leg of the read mux)
//   irq        - level interrupt, STATUS.EXP & CTRL.IE
module timer_mmio #(
   parameter int unsigned   N    = 32,
   parameter logic [N-1:0]  BASE = N'(32'h5200)
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         WEtimer,
   input  logic [N-1:0] DataAdr,
   input  logic [N-1:0] WriteData,
   output logic [N-1:0] ReadData,
   output logic         irq
);

   localparam int unsigned PW = 8;

   localparam logic [N-1:0] ADR_CTRL   = BASE;
   localparam logic [N-1:0] ADR_LOAD   = BASE + N'(4);
   localparam logic [N-1:0] ADR_COUNT  = BASE + N'(8);
   localparam logic [N-1:0] ADR_STATUS = BASE + N'(12);
   localparam logic [N-1:0] ADR_PRESC  = BASE + N'(16);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t          state, state_nxt;
   logic            ar, ie, expf;
   logic [N-1:0]    load, count;
   logic [PW-1:0]   presc, pc;

   logic            wr_ok, wr_ctrl, wr_load, wr_status, wr_presc;
   logic            en_wr, dis_wr;
   logic            start_c, run_c, tick_c, expire_c;

   // Write decode: aligned, enabled stores to a mapped register only
   assign wr_ok     = WEtimer && (DataAdr[1:0] == 2'b00);
   assign wr_ctrl   = wr_ok && (DataAdr == ADR_CTRL);
   assign wr_load   = wr_ok && (DataAdr == ADR_LOAD);
   assign wr_status = wr_ok && (DataAdr == ADR_STATUS);
   assign wr_presc  = wr_ok && (DataAdr == ADR_PRESC);
   assign en_wr     = wr_ctrl &&  WriteData[0];
   assign dis_wr    = wr_ctrl && !WriteData[0];

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (en_wr) state_nxt = RUN;
         RUN: begin
            if (dis_wr)                state_nxt = IDLE;
            else if (expire_c && !ar)  state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control strobes; a disabling write freezes COUNT/PC on that same edge
   always_comb begin
      start_c  = 1'b0;
      run_c    = 1'b0;
      tick_c   = 1'b0;
      expire_c = 1'b0;
      case (state)
         IDLE, DONE: start_c = en_wr;
         RUN: begin
            run_c    = !dis_wr;
            tick_c   = !dis_wr && (pc == presc);
            expire_c = !dis_wr && (pc == presc) && (count == '0);
         end
         default: ;
      endcase
   end

   // Configuration registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ar    <= 1'b0;
         ie    <= 1'b0;
         load  <= '0;
         presc <= '0;
      end else begin
         if (wr_ctrl) begin
            ar <= WriteData[1];
            ie <= WriteData[2];
         end
         if (wr_load)  load  <= WriteData;
         if (wr_presc) presc <= WriteData[PW-1:0];
      end
   end

   // Counter and prescaler; PC wraps at 8 bits if PRESC drops below it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         pc    <= '0;
      end else if (start_c) begin
         count <= load;
         pc    <= '0;
      end else if (run_c) begin
         pc <= tick_c ? '0 : pc + PW'(1);
         if (tick_c) begin
            if (count != '0) count <= count - N'(1);
            else if (ar)     count <= load;
         end
      end
   end

   // Expiry flag; a set in the same cycle as a W1C clear wins
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                         expf <= 1'b0;
      else if (expire_c)                    expf <= 1'b1;
      else if (wr_status && WriteData[0])   expf <= 1'b0;
   end

   assign irq = expf & ie;

   // Read mux; EN is derived from the running state
   always_comb begin
      ReadData = '0;
      if (DataAdr[1:0] == 2'b00) begin
         if      (DataAdr == ADR_CTRL)   ReadData = N'({ie, ar, (state == RUN)});
         else if (DataAdr == ADR_LOAD)   ReadData = load;
         else if (DataAdr == ADR_COUNT)  ReadData = count;
         else if (DataAdr == ADR_STATUS) ReadData = N'(expf);
         else if (DataAdr == ADR_PRESC)  ReadData = N'(presc);
      end
   end

endmodule

// File: tb/tb_timer_mmio.sv
// tb_timer_mmio: directed, table-driven bench for timer_mmio plus
// hand-written multi-cycle sequences.
module tb_timer_mmio;

   localparam logic [31:0] B  = 32'h5200;
   localparam logic [31:0] CT = B;
   localparam logic [31:0] LD = B + 32'd4;
   localparam logic [31:0] CN = B + 32'd8;
   localparam logic [31:0] ST = B + 32'd12;
   localparam logic [31:0] PS = B + 32'd16;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        we;
   logic [31:0] adr;
   logic [31:0] wd;
   logic [31:0] rdata;
   logic        irq;

   int          n_chk  = 0;
   int          n_pass = 0;

   timer_mmio #(.N(32), .BASE(32'h5200)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .WEtimer   (we),
      .DataAdr   (adr),
      .WriteData (wd),
      .ReadData  (rdata),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        irq;
   } vec_t;

   localparam int NV = 25;
   vec_t vt [NV];

   function automatic vec_t mk(input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] r,
                               input logic i);
      vec_t v;
      v.we = w; v.adr = a; v.wd = d; v.rd = r; v.irq = i;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else             n_pass++;
   endtask

   // One store cycle: drive at negedge, hold across the rising edge
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      we = 1'b1; adr = a; wd = d;
      @(posedge clk);
      #1;
      we = 1'b0; adr = '0; wd = '0;
   endtask

   task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] e);
      we = 1'b0; adr = a;
      #1;
      check(nm, rdata, e);
   endtask

   task automatic chk_irq(input string nm, input logic e);
      check(nm, {31'b0, irq}, {31'b0, e});
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Each row is one cycle: read checked just before the edge, write applied on it
      vt[0]  = mk(0, CT, 0,          0,     0);
      vt[1]  = mk(0, CN, 0,          0,     0);
      vt[2]  = mk(1, LD, 3,          0,     0);
      vt[3]  = mk(1, PS, 0,          0,     0);
      vt[4]  = mk(1, CT, 1,          0,     0);
      vt[5]  = mk(0, CN, 0,          3,     0);
      vt[6]  = mk(0, CN, 0,          2,     0);
      vt[7]  = mk(0, CN, 0,          1,     0);
      vt[8]  = mk(0, CN, 0,          0,     0);
      vt[9]  = mk(0, ST, 0,          1,     0);
      vt[10] = mk(0, CT, 0,          0,     0);
      vt[11] = mk(0, CN, 0,          0,     0);
      vt[12] = mk(1, ST, 1,          1,     0);
      vt[13] = mk(0, ST, 0,          0,     0);
      vt[14] = mk(0, CT, 1,          0,     0);
      vt[15] = mk(0, CN, 0,          0,     0);
      vt[16] = mk(1, B + 32'd2, 1,   0,     0);
      vt[17] = mk(0, CT, 0,          0,     0);
      vt[18] = mk(1, CN, 5,          0,     0);
      vt[19] = mk(0, CN, 0,          0,     0);
      vt[20] = mk(0, B + 32'h14, 0,  0,     0);
      vt[21] = mk(1, LD, 32'h1234,   3,     0);
      vt[22] = mk(0, LD, 0,          32'h1234, 0);
      vt[23] = mk(1, PS, 32'h1FF,    0,     0);
      vt[24] = mk(0, PS, 0,          32'hFF, 0);

      reset_n = 1'b0; we = 1'b0; adr = '0; wd = '0;
      #12;
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         we = vt[i].we; adr = vt[i].adr; wd = vt[i].wd;
         #2;
         check($sformatf("vec%0d_rd", i), rdata, vt[i].rd);
         chk_irq($sformatf("vec%0d_irq", i), vt[i].irq);
         @(posedge clk);
         #1;
         we = 1'b0;
      end

      // Prescaled auto-reload: expiry 6 cycles after enable
      wr(LD, 1); wr(PS, 2); wr(CT, 3);
      cycles(5);
      rd("ar_st_before", ST, 0);
      rd("ar_cn_before", CN, 0);
      cycles(1);
      rd("ar_st_set", ST, 1);
      rd("ar_cn_reload", CN, 1);
      rd("ar_ctrl", CT, 3);
      cycles(6);
      rd("ar_st_sticky", ST, 1);
      wr(ST, 1);
      rd("ar_st_clr", ST, 0);
      wr(CT, 0);

      // Interrupt and set-beats-clear
      wr(PS, 0); wr(LD, 1); wr(CT, 7);
      chk_irq("irq_idle", 0);
      cycles(2);
      chk_irq("irq_set", 1);
      rd("irq_st", ST, 1);
      wr(ST, 1);
      rd("irq_st_clr", ST, 0);
      chk_irq("irq_clr", 0);
      wr(ST, 1);
      rd("setwins_st", ST, 1);
      chk_irq("setwins_irq", 1);
      wr(CT, 0);
      wr(ST, 1);

      // Reset mid-count
      wr(LD, 10); wr(CT, 1);
      cycles(4);
      rd("rst_cn_pre", CN, 6);
      reset_n = 1'b0;
      rd("rst_ctrl", CT, 0);
      rd("rst_load", LD, 0);
      rd("rst_cn", CN, 0);
      chk_irq("rst_irq", 0);
      @(negedge clk);
      reset_n = 1'b1;
      cycles(3);
      rd("rst_cn_post", CN, 0);
      rd("rst_ctrl_post", CT, 0);

      // Deferred LOAD, hold on disable, restart, and EN=1 rewrite in RUN
      wr(LD, 8); wr(CT, 1);
      cycles(2);
      wr(LD, 2);
      rd("dl_cn5", CN, 5);
      wr(CT, 0);
      rd("dl_hold", CN, 5);
      cycles(3);
      rd("dl_hold2", CN, 5);
      wr(CT, 1);
      rd("dl_restart", CN, 2);
      cycles(1);
      rd("dl_cn1", CN, 1);
      wr(CT, 3);
      rd("norestart_cn", CN, 0);
      rd("norestart_ctrl", CT, 3);
      cycles(1);
      rd("newar_cn", CN, 2);
      rd("newar_st", ST, 1);
      wr(CT, 0);
      wr(ST, 1);

      // PRESC lowered below PC: PC wraps at 8 bits before the next tick
      wr(LD, 1); wr(PS, 5); wr(CT, 1);
      cycles(3);
      wr(PS, 1);
      cycles(253);
      rd("wrap_cn_before", CN, 1);
      cycles(1);
      rd("wrap_cn_tick", CN, 0);
      wr(CT, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
